seg_scan_mux: RTL and testbench
===============================

# seg_scan_mux

Parametrised time-multiplexed driver for 7-segment display banks. It scans N_PHASE phases, presents N_DIGIT segment bytes per phase and one-hot drives the phase select lines. It adds a blanking interval at each phase change to suppress ghosting, PWM brightness control and a freeze mode. It sits between the display-data registers and the board's segment/select pins.

## Interface
- N_PHASE, 4: number of scan phases (2..16).
- N_DIGIT, 8: segment bytes presented per phase.
- DWELL, 65536: clock cycles per phase (>= 16).
- BLANK, 256: select-off cycles at the start of each phase (1 <= BLANK < DWELL).
- SEL_W, 9: select bus width (>= N_PHASE).
- SEL_ACTIVE_HIGH, 1: select polarity; 0 inverts all SEG_SEL bits.
- RST_PATTERN, 8'hFC: per-digit segment value at reset.
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-low.
- SEG_DATA  in  N_PHASE*N_DIGIT*8  flattened data. Phase p, digit d occupies bits [(p*N_DIGIT+d)*8 +: 8]. Digit 0 maps to SEG_OUT[7:0].
- BRIGHT  in  4  brightness; 0 = dark, 15 = full.
- FREEZE  in  1  hold current phase while high.
- SEG_OUT  out  N_DIGIT*8  segment bytes for the current phase.
- SEG_SEL  out  SEL_W  one-hot phase select.
- PHASE  out  clog2(N_PHASE)  current phase index.
- FRAME_TICK  out  1  one-cycle pulse at frame wrap.

## Operation
- State: dwell counter cnt (0..DWELL-1), phase index ph (0..N_PHASE-1). All outputs are registered.
- Reset (RST low, asynchronous, any time including mid-phase):
  - cnt = 0, ph = 0.
  - SEG_OUT = RST_PATTERN replicated across all digits.
  - SEG_SEL = all inactive.
  - FRAME_TICK = 0, PHASE = 0.
- cnt increments every cycle. At cnt == DWELL-1 it wraps to 0.
- Phase advance at the cnt wrap:
  - FREEZE low: ph increments, wrapping N_PHASE-1 -> 0.
  - FREEZE high (sampled on the wrap cycle): ph holds. cnt still wraps, and blanking and relatch still occur.
- Data latch: on the clock edge ending the cycle where cnt == 0, SEG_OUT loads the SEG_DATA slice for ph. SEG_DATA changes at any other time have no effect until the next phase's latch.
- Select gating: bit ph of SEG_SEL is active in cycles where cnt >= BLANK and gate is true.
  - gate = (BRIGHT == 15) || (cnt[3:0] < BRIGHT).
  - BRIGHT is sampled every cycle.
  - BRIGHT == 0 keeps all selects inactive.
- Inactive select bits:
  - all bits other than ph are always inactive;
  - bits N_PHASE..SEL_W-1 are never active.
- Inactive level is 0 when SEL_ACTIVE_HIGH=1, and 1 otherwise.
- FRAME_TICK is high for exactly the one cycle in which ph == 0 and cnt == 0 following a wrap from N_PHASE-1. It does not fire after reset or during freeze.
- PHASE mirrors ph.

## Timing
- Phase period is exactly DWELL cycles. Frame period is N_PHASE*DWELL cycles.
- Within each phase:
  - select is dark for cycles cnt = 0..BLANK-1;
  - SEG_OUT is valid from cnt = 1;
  - select may be active for cnt = BLANK..DWELL-1.
- With BLANK = 1, SEG_OUT and select change on the same edge.
- Data latency: SEG_DATA is sampled once per phase at the cnt==0 -> 1 edge, so worst-case latency to display is N_PHASE*DWELL + 1 cycles.
- Duty per phase with BRIGHT = b (0 < b < 15): b/16 of the cycles in the active window. b = 15 gives 100%.
- FREEZE raised mid-phase takes effect at the next wrap. FREEZE lowered resumes advance at the following wrap.

## Test plan
Parameters for all scenarios: N_PHASE=4, N_DIGIT=2, DWELL=32, BLANK=4, SEL_W=9.

- **Reset:** hold RST low, then release.
  - While low: SEG_OUT=16'hFCFC, SEG_SEL=9'h000, PHASE=0, FRAME_TICK=0.
  - After release: first latch at cycle 1 loads phase-0 data.
- **Full scan:** SEG_DATA phases 0..3 = 16'h1111, 16'h2222, 16'h3333, 16'h4444; BRIGHT=15.
  - SEG_SEL sequence: 001, 002, 004, 008, each active for 28 cycles after 4 dark cycles.
  - SEG_OUT matches each phase's data.
  - FRAME_TICK pulses once every 128 cycles.
- **Brightness:** BRIGHT=4.
  - Select is active on cnt 16..19 only (cnt[3:0] < 4 within the cnt>=4 window).
  - BRIGHT=0 gives SEG_SEL=0 permanently.
- **Freeze:** raise FREEZE during phase 2.
  - PHASE stays 2 across 3 dwell periods.
  - SEG_OUT re-latches new phase-2 data each period.
  - No FRAME_TICK.
  - Lowering FREEZE advances to phase 3 at the next wrap.
- **Mid-operation reset:** assert RST at cnt=17, phase 3.
  - Outputs return to reset values immediately (asynchronously).
  - Scan restarts at phase 0.
- **Polarity:** with SEL_ACTIVE_HIGH=0, repeat the full scan.
  - SEG_SEL idles at 9'h1FF.
  - Active phase drives 9'h1FE, 9'h1FD, 9'h1FB, 9'h1F7.

Source files
------------

// File: rtl/seg_scan_mux_if.sv
// Display-side bundle for seg_scan_mux: frame data and controls in,
// segment/select pins and scan status out.
interface seg_scan_mux_if #(
  parameter int N_PHASE = 4,
  parameter int N_DIGIT = 8,
  parameter int SEL_W   = 9
);
  localparam int PH_W = $clog2(N_PHASE);

  logic [N_PHASE*N_DIGIT*8-1:0] SEG_DATA;
  logic [3:0]                   BRIGHT;
  logic                         FREEZE;
  logic [N_DIGIT*8-1:0]         SEG_OUT;
  logic [SEL_W-1:0]             SEG_SEL;
  logic [PH_W-1:0]              PHASE;
  logic                         FRAME_TICK;

  modport master (
    output SEG_DATA, BRIGHT, FREEZE,
    input  SEG_OUT, SEG_SEL, PHASE, FRAME_TICK
  );

  modport slave (
    input  SEG_DATA, BRIGHT, FREEZE,
    output SEG_OUT, SEG_SEL, PHASE, FRAME_TICK
  );
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment scan driver: phase dwell counter, per-phase data
// latch, blanked and PWM-gated one-hot select, freeze and frame tick.
module seg_scan_digit #(
  parameter logic [7:0] RST_PATTERN = 8'hFC
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       en,
  input  logic [7:0] d,
  output logic [7:0] q
);
  always_ff @(posedge CLK or negedge RST)
    if (!RST)   q <= RST_PATTERN;
    else if (en) q <= d;
endmodule

module seg_scan_mux #(
  parameter int         N_PHASE         = 4,
  parameter int         N_DIGIT         = 8,
  parameter int         DWELL           = 65536,
  parameter int         BLANK           = 256,
  parameter int         SEL_W           = 9,
  parameter bit         SEL_ACTIVE_HIGH = 1'b1,
  parameter logic [7:0] RST_PATTERN     = 8'hFC
) (
  input logic           CLK,
  input logic           RST,
  seg_scan_mux_if.slave bus
);
  localparam int               PH_W     = $clog2(N_PHASE);
  localparam int               CNT_W    = $clog2(DWELL);
  localparam logic [SEL_W-1:0] SEL_IDLE = {SEL_W{~SEL_ACTIVE_HIGH}};

  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic [PH_W-1:0]      ph, ph_nx;
  logic                 wrap, gate_nx, lit_nx, tick_q;
  logic [SEL_W-1:0]     sel_q, sel_nx;
  logic [N_DIGIT*8-1:0] ph_data, seg_q;

  assign wrap = (cnt == CNT_W'(DWELL-1));

  always_comb begin
    cnt_nx = wrap ? '0 : cnt + 1'b1;
    ph_nx  = ph;
    if (wrap && !bus.FREEZE)
      ph_nx = (ph == PH_W'(N_PHASE-1)) ? '0 : ph + 1'b1;
  end

  // Select is registered, so it is computed for the cycle about to start.
  assign gate_nx = (bus.BRIGHT == 4'd15) || (cnt_nx[3:0] < bus.BRIGHT);
  assign lit_nx  = gate_nx && (cnt_nx >= CNT_W'(BLANK));

  always_comb begin
    sel_nx = SEL_IDLE;
    if (lit_nx) sel_nx[ph_nx] = SEL_ACTIVE_HIGH;
  end

  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      cnt    <= '0;
      ph     <= '0;
      sel_q  <= SEL_IDLE;
      tick_q <= 1'b0;
    end else begin
      cnt    <= cnt_nx;
      ph     <= ph_nx;
      sel_q  <= sel_nx;
      tick_q <= wrap && !bus.FREEZE && (ph == PH_W'(N_PHASE-1));
    end

  always_comb begin
    ph_data = '0;
    for (int p = 0; p < N_PHASE; p++)
      if (ph == PH_W'(p)) ph_data = bus.SEG_DATA[p*N_DIGIT*8 +: N_DIGIT*8];
  end

  // Data is captured once per phase, at the edge leaving cnt == 0.
  for (genvar d = 0; d < N_DIGIT; d++) begin : g_dig
    seg_scan_digit #(.RST_PATTERN(RST_PATTERN)) u_dig (
      .CLK (CLK),
      .RST (RST),
      .en  (cnt == '0),
      .d   (ph_data[d*8 +: 8]),
      .q   (seg_q[d*8 +: 8])
    );
  end

  assign bus.SEG_OUT    = seg_q;
  assign bus.SEG_SEL    = sel_q;
  assign bus.PHASE      = ph;
  assign bus.FRAME_TICK = tick_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboarded bench for seg_scan_mux: active-high and active-low instances
// run side by side through reset, scan, brightness, freeze and mid-phase reset.
module tb_seg_scan_mux;
  localparam int NP = 4, ND = 2, DW = 32, BL = 4, SW = 9;

  typedef struct packed {
    logic [15:0] seg;
    logic [8:0]  sel;
    logic [1:0]  ph;
    logic        tick;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  seg_scan_mux_if #(.N_PHASE(NP), .N_DIGIT(ND), .SEL_W(SW)) u_if ();
  seg_scan_mux_if #(.N_PHASE(NP), .N_DIGIT(ND), .SEL_W(SW)) u_ifn ();

  seg_scan_mux #(.N_PHASE(NP), .N_DIGIT(ND), .DWELL(DW), .BLANK(BL), .SEL_W(SW),
                 .SEL_ACTIVE_HIGH(1'b1), .RST_PATTERN(8'hFC))
    u_dut (.CLK(CLK), .RST(RST), .bus(u_if));

  seg_scan_mux #(.N_PHASE(NP), .N_DIGIT(ND), .DWELL(DW), .BLANK(BL), .SEL_W(SW),
                 .SEL_ACTIVE_HIGH(1'b0), .RST_PATTERN(8'hFC))
    u_dutn (.CLK(CLK), .RST(RST), .bus(u_ifn));

  int          n_tests = 0, n_fail = 0;
  exp_t        sb[$];
  logic [63:0] data;
  logic [3:0]  bright;
  logic        freeze;
  int          m_cnt, m_ph;
  logic [15:0] m_seg;
  int          ticks, lit;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    u_if.SEG_DATA  = data;  u_ifn.SEG_DATA = data;
    u_if.BRIGHT    = bright; u_ifn.BRIGHT  = bright;
    u_if.FREEZE    = freeze; u_ifn.FREEZE  = freeze;
  endtask

  task automatic model_reset();
    m_cnt = 0; m_ph = 0; m_seg = 16'hFCFC;
    sb.delete();
  endtask

  // Drive current inputs and queue what the DUT must show after the next edge.
  task automatic advance();
    exp_t e;
    int   n_cnt, n_ph;
    drive();
    n_cnt = (m_cnt == DW-1) ? 0 : m_cnt + 1;
    n_ph  = m_ph;
    if (m_cnt == DW-1 && !freeze) n_ph = (m_ph + 1) % NP;
    e.tick = (m_cnt == DW-1) && !freeze && (m_ph == NP-1);
    if (m_cnt == 0) m_seg = data[m_ph*16 +: 16];
    e.seg = m_seg;
    e.sel = '0;
    if (n_cnt >= BL && (bright == 4'd15 || (n_cnt % 16) < int'(bright)))
      e.sel[n_ph] = 1'b1;
    e.ph = n_ph[1:0];
    sb.push_back(e);
    m_cnt = n_cnt;
    m_ph  = n_ph;
  endtask

  task automatic step();
    exp_t       e;
    logic [8:0] seln;
    @(negedge CLK);
    if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
    else begin
      e    = sb.pop_front();
      seln = ~e.sel;
      chk("seg_out",   u_if.SEG_OUT,     e.seg);
      chk("seg_sel",   u_if.SEG_SEL,     e.sel);
      chk("phase",     u_if.PHASE,       e.ph);
      chk("tick",      u_if.FRAME_TICK,  e.tick);
      chk("seg_sel_n", u_ifn.SEG_SEL,    seln);
      chk("seg_out_n", u_ifn.SEG_OUT,    e.seg);
    end
    if (u_if.FRAME_TICK) ticks++;
    if (u_if.SEG_SEL != '0) lit++;
    advance();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_seg"},   u_if.SEG_OUT,    16'hFCFC);
    chk({tag, "_sel"},   u_if.SEG_SEL,    9'h000);
    chk({tag, "_phase"}, u_if.PHASE,      2'd0);
    chk({tag, "_tick"},  u_if.FRAME_TICK, 1'b0);
    chk({tag, "_sel_n"}, u_ifn.SEG_SEL,   9'h1FF);
    chk({tag, "_seg_n"}, u_ifn.SEG_OUT,   16'hFCFC);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0;
    data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    bright = 4'd15; freeze = 1'b0; ticks = 0; lit = 0;
    drive();
    model_reset();
    repeat (3) @(negedge CLK);
    chk_reset_vals("rst");

    // Release and full scan
    RST = 1'b1;
    advance();
    run(20);
    ticks = 0;
    run(256);
    chk("tick_rate", ticks, 2);

    // Brightness 4: cnt 16..19 lit out of each 32-cycle phase
    bright = 4'd4;
    run(40);
    for (int g = 0; g < 64 && m_cnt != 0; g++) step();
    lit = 0;
    run(32);
    chk("bright4_lit", lit, 4);
    bright = 4'd0;
    run(2);
    lit = 0;
    run(64);
    chk("bright0_lit", lit, 0);

    // Freeze during phase 2, reloading phase-2 data each period
    bright = 4'd15;
    for (int g = 0; g < 200 && !(m_ph == 2 && m_cnt == 10); g++) step();
    freeze = 1'b1;
    ticks = 0;
    for (int k = 0; k < 3; k++) begin
      data[47:32] = 16'hA5A0 + 16'(k);
      run(32);
    end
    chk("frz_phase", u_if.PHASE, 2'd2);
    chk("frz_ticks", ticks, 0);
    freeze = 1'b0;
    for (int g = 0; g < 64 && m_ph != 3; g++) step();
    step();
    chk("unfrz_phase", u_if.PHASE, 2'd3);

    // Asynchronous reset at cnt 17 of phase 3
    for (int g = 0; g < 200 && !(m_cnt == 17 && m_ph == 3); g++) step();
    @(posedge CLK);
    #2;
    chk("pre_rst_phase", u_if.PHASE, 2'd3);
    chk("pre_rst_sel",   u_if.SEG_SEL, 9'h008);
    RST = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    advance();
    run(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
